la_spram_bist: RTL and testbench
================================

Name: la_spram_bist

Overview:
- March C- built-in self-test engine for a single-port RAM.
- Acts as the initiator on the la_spram memory port: drives ce/we/wmask/addr/din and checks dout with 1-cycle read latency.
- Sits beside each hardened memory and is muxed onto the port by the integrating block during test mode.
- Reports pass/fail and first-failure diagnostics.

Parameters:
- DW, 32, memory data width (>=1).
- AW, 10, memory address width (>=1); N = 2**AW words tested.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin test; sampled only when busy=0.
- busy  output  1  test in progress.
- done  output  1  test complete; held until next accepted start or reset.
- fail  output  1  sticky; any miscompare during the current run.
- fail_addr  output  AW  address of first miscompare.
- fail_bits  output  DW  expected XOR actual at first miscompare.
- mem_ce  output  1  memory chip enable.
- mem_we  output  1  memory write enable.
- mem_wmask  output  DW  per-bit write mask; all ones whenever mem_we=1, else 0.
- mem_addr  output  AW  memory address.
- mem_din  output  DW  write data.
- mem_dout  input  DW  read data; valid the cycle after a read is sampled.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM=IDLE. Reset mid-run aborts; mem_ce=0 from the cycle after the reset edge.
- FSM states: IDLE -> RUN -> FLUSH -> DONE -> (start) RUN.
- Start acceptance (IDLE or DONE, start=1):
  - clears done, fail, fail_addr, fail_bits;
  - sets busy;
  - enters RUN at element 0, address 0.
  - start is ignored while busy=1.
- March C- with background B=0 (all zeros) and ~B (all ones), run in order:
  - E0 up(w B)
  - E1 up(r B, w ~B)
  - E2 up(r ~B, w B)
  - E3 down(r B, w ~B)
  - E4 down(r ~B, w B)
  - E5 up(r B)
- Address order: "up" = 0..N-1; "down" = N-1..0.
- Two-op elements: read then write at the same address; address advances every 2 cycles.
- Throughput: one memory op per cycle, no stalls. 10N ops total: 5N writes, 5N reads.
- Timing: start sampled at edge 0; op k is sampled by the memory at edge k+1.
- Compare pipeline:
  - each read registers its expected value and address;
  - mem_dout is compared on the next edge;
  - on the first miscompare: fail=1, and fail_addr and fail_bits are captured;
  - later miscompares leave fail_addr and fail_bits unchanged.
- FLUSH: one cycle after the last op, for the final compare.
- Completion: at edge 10N+1, busy=0 and done=1.
- Idle port: in IDLE, FLUSH and DONE, mem_ce=0, mem_we=0, mem_wmask=0; mem_addr and mem_din hold 0.
- Counter wrap: the address counter wraps within an element; no out-of-range address is ever driven.

Optional Feature:
- Macro: LA_SPRAM_BIST_CHECKERBOARD_EN.
- Defined:
  - after the solid-background pass, a second full March C- pass runs with B = alternating 0101... (bit0=1, i.e. DW'h...55), ~B as complement;
  - done at edge 20N+1;
  - fail state is shared across both passes; first failure is captured from either pass.
- Undefined: solid pass only; no pass counter is synthesized.

Test Plan (DW=8, AW=4, N=16, behavioural 1-cycle-latency RAM model):
- Fault-free RAM, start pulse:
  - busy=1 the next cycle; done=1 at edge 161; fail=0;
  - exactly 80 writes and 80 reads observed;
  - first op: mem_we=1, addr 0, din 8'h00, wmask 8'hFF.
- Bit 3 of address 5 stuck-at-0:
  - fail=1, fail_addr=5, fail_bits=8'h08, first set during E2 (read ~B at addr 5).
- Address alias (addr 9 decodes to cell 1):
  - fail=1, fail_addr=9, fail_bits=8'hFF, first set during E1.
- Reset mid-run:
  - reset at edge 50: mem_ce=0, busy=0, done=0, fail=0 the next cycle;
  - a following start completes with done at 161 cycles and fail=0.
- Start pulses while busy=1 have no effect; done rises exactly once.
- Checkerboard pass (macro defined, fault-free):
  - done at edge 321, fail=0;
  - write at op 160 has din=8'h55.

Source files
------------

// File: rtl/la_spram_bist.sv
`default_nettype none
// ============================================================================
// Module   : la_spram_bist
// Purpose  : March C- built-in self-test engine for a single-port RAM with
//            1-cycle read latency. Drives the la_spram port one op per cycle
//            and reports pass/fail with first-failure diagnostics.
//
// Sequence (B = background, ~B = complement):
//   E0 up(w B)  E1 up(r B,w ~B)  E2 up(r ~B,w B)
//   E3 dn(r B,w ~B)  E4 dn(r ~B,w B)  E5 up(r B)
//
// Build option : LA_SPRAM_BIST_CHECKERBOARD_EN
//   defined   -> a second pass runs with B = ...0101 (bit0 = 1)
//   undefined -> solid-zero background pass only
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             begin test (ignored while busy)
//   busy, done, fail  status; done held until next start, fail sticky
//   fail_addr/bits    address and expected^actual of first miscompare
//   mem_ce/we/wmask   memory controls (wmask all ones on writes, else 0)
//   mem_addr/din      memory address and write data
//   mem_dout          memory read data, valid the cycle after a read
//
// Revision : 1.0 - initial release
// ============================================================================
module la_spram_bist #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_bits,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [DW-1:0] mem_wmask,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      elem;       // March element 0..5
  logic [AW-1:0]   cnt;        // logical address counter, 0..N-1 within an element
  logic            phase;      // 0 = read op, 1 = write op in two-op elements
  logic            rd_pend;    // a read was sampled by the memory at the last edge
  logic [DW-1:0]   exp_data;
  logic [AW-1:0]   rd_addr;

  logic            accept;
  logic            op_rd;
  logic [DW-1:0]   op_exp;
  logic            single_op;
  logic            is_down;
  logic            step_addr;
  logic            elem_last;
  logic            final_pass;
  logic [DW-1:0]   bg;
  logic [DW-1:0]   bg_n;

`ifdef LA_SPRAM_BIST_CHECKERBOARD_EN
  function automatic logic [DW-1:0] alt_pattern();
    logic [DW-1:0] p;
    for (int i = 0; i < DW; i++) begin
      p[i] = (i % 2 == 0);
    end
    return p;
  endfunction

  localparam logic [DW-1:0] CHECKER = alt_pattern();

  logic pass;

  always_ff @(posedge clk) begin
    if (reset) begin
      pass <= 1'b0;
    end else if (accept) begin
      pass <= 1'b0;
    end else if (state == S_RUN && elem_last && elem == 3'd5) begin
      pass <= 1'b1;
    end
  end

  assign bg         = pass ? CHECKER : '0;
  assign final_pass = pass;
`else
  assign bg         = '0;
  assign final_pass = 1'b1;
`endif

  assign bg_n      = ~bg;
  assign single_op = (elem == 3'd0) || (elem == 3'd5);
  assign is_down   = (elem == 3'd3) || (elem == 3'd4);
  // The address counter moves after every single-op cycle or the write half of a pair.
  assign step_addr = single_op || phase;
  assign elem_last = step_addr && (cnt == {AW{1'b1}});

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    op_rd     = 1'b0;
    op_exp    = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        mem_ce   = 1'b1;
        // Descending elements walk N-1..0 by complementing the up-counter.
        mem_addr = is_down ? ~cnt : cnt;
        if (elem == 3'd0) begin
          mem_we  = 1'b1;
          mem_din = bg;
        end else if (elem == 3'd5) begin
          op_rd  = 1'b1;
          op_exp = bg;
        end else if (!phase) begin
          op_rd  = 1'b1;
          op_exp = (elem == 3'd1 || elem == 3'd3) ? bg : bg_n;
        end else begin
          mem_we  = 1'b1;
          mem_din = (elem == 3'd1 || elem == 3'd3) ? bg_n : bg;
        end
        if (elem_last && elem == 3'd5 && final_pass) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_wmask = mem_we ? {DW{1'b1}} : {DW{1'b0}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      elem      <= 3'd0;
      cnt       <= '0;
      phase     <= 1'b0;
      rd_pend   <= 1'b0;
      exp_data  <= '0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_bits <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= op_rd;
      if (op_rd) begin
        exp_data <= op_exp;
        rd_addr  <= mem_addr;
      end

      // Read data from the previous edge is on mem_dout now.
      if (rd_pend && (mem_dout != exp_data) && !fail) begin
        fail      <= 1'b1;
        fail_addr <= rd_addr;
        fail_bits <= exp_data ^ mem_dout;
      end

      if (state == S_RUN) begin
        if (step_addr) begin
          phase <= 1'b0;
          cnt   <= cnt + AW'(1);
          if (elem_last) begin
            elem <= (elem == 3'd5) ? 3'd0 : 3'(elem + 3'd1);
          end
        end else begin
          phase <= 1'b1;
        end
      end

      if (state == S_FLUSH) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      if (accept) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_bits <= '0;
        elem      <= 3'd0;
        cnt       <= '0;
        phase     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_la_spram_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_la_spram_bist
// Purpose  : Directed self-checking bench for la_spram_bist (DW=8, AW=4)
//            with a behavioural 1-cycle-latency RAM that can inject a
//            stuck-at bit or an address alias.
// Revision : 1.0 - initial release
// ============================================================================
module tb_la_spram_bist;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 16;
`ifdef LA_SPRAM_BIST_CHECKERBOARD_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int DONE_EDGE = 10 * N * PASSES + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_bits;
  logic          mem_ce, mem_we;
  logic [DW-1:0] mem_wmask, mem_din;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0;

  la_spram_bist #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_bits(fail_bits),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_wmask(mem_wmask),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Behavioural RAM. fault_mode: 0 none, 1 addr5 bit3 stuck-at-0, 2 addr9 -> cell 1.
  logic [DW-1:0] ram [0:N-1];
  int fault_mode = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int bad_mask = 0;

  function automatic int phys(input logic [AW-1:0] a);
    if (fault_mode == 2 && a == 4'd9) return 1;
    return int'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) begin
        if (fault_mode == 1 && phys(mem_addr) == 5)
          ram[phys(mem_addr)] <= mem_din & ~8'h08;
        else
          ram[phys(mem_addr)] <= mem_din;
        wr_cnt = wr_cnt + 1;
        if (mem_wmask !== 8'hFF) bad_mask = bad_mask + 1;
      end else begin
        mem_dout <= ram[phys(mem_addr)];
        rd_cnt = rd_cnt + 1;
        if (mem_wmask !== 8'h00) bad_mask = bad_mask + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  int       done_edge;
  int       first_fail_edge;
  int       done_rises;
  logic     op160_we;
  logic [DW-1:0] op160_din;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start into one edge (edge 0 of the run).
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Observes edges 1..budget after the start edge; optionally pokes start while busy.
  task automatic run_for(input int budget, input bit poke);
    logic prev_done;
    done_edge       = -1;
    first_fail_edge = -1;
    done_rises      = 0;
    op160_we        = 1'b0;
    op160_din       = 'x;
    prev_done       = done;
    for (int e = 1; e <= budget; e++) begin
      start = poke && busy && (e % 7 == 3);
      tick();
      if (e == 160) begin
        op160_we  = mem_we;
        op160_din = mem_din;
      end
      if (fail && first_fail_edge < 0) first_fail_edge = e;
      if (done && !prev_done) begin
        done_rises++;
        if (done_edge < 0) done_edge = e;
      end
      prev_done = done;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, fail, mem_ce, mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_status: got busy/done/fail/ce/we=%b required 00000", {busy, done, fail, mem_ce, mem_we});
    end
    checks++;
    if (mem_addr !== 4'h0 || mem_din !== 8'h00 || mem_wmask !== 8'h00 || fail_addr !== 4'h0 || fail_bits !== 8'h00) begin
      errors++; $display("FAIL reset_bus: got addr=%h din=%h wmask=%h faddr=%h fbits=%h required all 0", mem_addr, mem_din, mem_wmask, fail_addr, fail_bits);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fault_free();
    int wr0, rd0, bad0;
    fault_mode = 0;
    wr0 = wr_cnt; rd0 = rd_cnt; bad0 = bad_mask;
    do_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b required 1", busy);
    end
    checks++;
    if (mem_ce !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'h0 || mem_din !== 8'h00 || mem_wmask !== 8'hFF) begin
      errors++; $display("FAIL first_op: got ce=%b we=%b addr=%h din=%h wmask=%h required 1 1 0 00 ff", mem_ce, mem_we, mem_addr, mem_din, mem_wmask);
    end
    run_for(DONE_EDGE + 4, 1'b0);
    checks++;
    if (done_edge !== DONE_EDGE) begin
      errors++; $display("FAIL done_edge: got %0d required %0d", done_edge, DONE_EDGE);
    end
    checks++;
    if (fail !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL clean_status: got fail=%b busy=%b done=%b required 0 0 1", fail, busy, done);
    end
    checks++;
    if (wr_cnt - wr0 != 5 * N * PASSES || rd_cnt - rd0 != 5 * N * PASSES) begin
      errors++; $display("FAIL op_counts: got writes=%0d reads=%0d required %0d each", wr_cnt - wr0, rd_cnt - rd0, 5 * N * PASSES);
    end
    checks++;
    if (bad_mask != bad0) begin
      errors++; $display("FAIL wmask: got %0d bad-mask ops required 0", bad_mask - bad0);
    end
    checks++;
    if (mem_ce !== 1'b0 || mem_addr !== 4'h0 || mem_din !== 8'h00) begin
      errors++; $display("FAIL idle_port: got ce=%b addr=%h din=%h required 0 0 00", mem_ce, mem_addr, mem_din);
    end
`ifdef LA_SPRAM_BIST_CHECKERBOARD_EN
    checks++;
    if (op160_we !== 1'b1 || op160_din !== 8'h55) begin
      errors++; $display("FAIL checker_op160: got we=%b din=%h required 1 55", op160_we, op160_din);
    end
`endif
  endtask

  task automatic test_stuck_bit();
    fault_mode = 1;
    do_start();
    run_for(DONE_EDGE + 2, 1'b0);
    checks++;
    if (fail !== 1'b1 || fail_addr !== 4'd5 || fail_bits !== 8'h08) begin
      errors++; $display("FAIL stuck_diag: got fail=%b addr=%0d bits=%h required 1 5 08", fail, fail_addr, fail_bits);
    end
    // E2 read of ~B at address 5 is op 58, compared at edge 60.
    checks++;
    if (first_fail_edge != 60) begin
      errors++; $display("FAIL stuck_edge: got %0d required 60", first_fail_edge);
    end
    fault_mode = 0;
  endtask

  task automatic test_alias();
    fault_mode = 2;
    do_start();
    checks++;
    if (fail !== 1'b0 || fail_addr !== 4'd0 || fail_bits !== 8'h00 || done !== 1'b0) begin
      errors++; $display("FAIL start_clears: got fail=%b addr=%h bits=%h done=%b required 0 0 00 0", fail, fail_addr, fail_bits, done);
    end
    run_for(DONE_EDGE + 2, 1'b0);
    checks++;
    if (fail !== 1'b1 || fail_addr !== 4'd9 || fail_bits !== 8'hFF) begin
      errors++; $display("FAIL alias_diag: got fail=%b addr=%0d bits=%h required 1 9 ff", fail, fail_addr, fail_bits);
    end
    // E1 read of address 9 is op 34, compared at edge 36.
    checks++;
    if (first_fail_edge != 36) begin
      errors++; $display("FAIL alias_edge: got %0d required 36", first_fail_edge);
    end
    fault_mode = 0;
  endtask

  task automatic test_reset_midrun();
    do_start();
    repeat (49) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (mem_ce !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: got ce=%b busy=%b done=%b fail=%b required 0 0 0 0", mem_ce, busy, done, fail);
    end
    reset = 1'b0;
    tick();
    do_start();
    run_for(DONE_EDGE + 2, 1'b0);
    checks++;
    if (done_edge != DONE_EDGE || fail !== 1'b0) begin
      errors++; $display("FAIL restart: got done_edge=%0d fail=%b required %0d 0", done_edge, fail, DONE_EDGE);
    end
  endtask

  task automatic test_start_while_busy();
    do_start();
    run_for(DONE_EDGE + 6, 1'b1);
    checks++;
    if (done_rises != 1 || done_edge != DONE_EDGE) begin
      errors++; $display("FAIL busy_start: got rises=%0d done_edge=%0d required 1 %0d", done_rises, done_edge, DONE_EDGE);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL done_held: got done=%b busy=%b required 1 0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_bit();
    test_alias();
    test_reset_midrun();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
